// File: rtl/vpg_pkg.sv
// Shared state encoding, default timing constants and counter sizing for the PLL mode sequencer.
// ST_FAULT exists only when PLL_SEQ_TIMEOUT_EN is defined.
package vpg_pkg;

   localparam int DEBOUNCE_CYCLES_DEF     = 50000;
   localparam int CHANGE_PULSE_CYCLES_DEF = 4;
   localparam int LOCK_TIMEOUT_CYCLES_DEF = 1000000;
   localparam int SETTLE_CYCLES_DEF       = 1024;
   localparam int CNT_MIN_W               = 20;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQUEST,
      ST_WAIT_UNLOCK,
      ST_WAIT_LOCK,
      ST_SETTLE
`ifdef PLL_SEQ_TIMEOUT_EN
      , ST_FAULT
`endif
   } state_e;

   // The shared phase counter must hold the largest reload value and never shrink below 20 bits.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      int w;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      w = $clog2(m + 1);
      return (w < CNT_MIN_W) ? CNT_MIN_W : w;
   endfunction

endpackage

// File: rtl/pll_mode_sequencer_if.sv
// Board-facing and controller-facing signal bundle of the PLL mode sequencer.
interface pll_mode_sequencer_if;

   logic [3:0] mode_sw;
   logic       pll_locked;
   logic [3:0] mode;
   logic       mode_change;
   logic       video_reset_n;
   logic       busy;
   logic       error;

   modport master (
      output mode_sw, pll_locked,
      input  mode, mode_change, video_reset_n, busy, error
   );

   modport slave (
      input  mode_sw, pll_locked,
      output mode, mode_change, video_reset_n, busy, error
   );

endinterface

// File: rtl/mode_debounce.sv
// Two-flop synchronizer plus stability debouncer for the 4-bit mode switches.
module mode_debounce
   import vpg_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] din,
   output logic [3:0] dout,
   output logic       stable
);

   localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DEB_W-1:0] CNT_MAX = DEB_W'(DEBOUNCE_CYCLES - 1);

   logic [3:0]       sync1_q, sync2_q, cand_q, cand_d;
   logic [DEB_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cand_d = cand_q;
      cnt_d  = cnt_q;
      if (sync2_q != cand_q) begin
         cand_d = sync2_q;
         cnt_d  = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + DEB_W'(1);
      end
   end

   // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         cand_q  <= '0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= din;
         sync2_q <= sync1_q;
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
      end
   end

   assign dout   = cand_q;
   assign stable = (cnt_q == CNT_MAX);

endmodule

// File: rtl/pll_mode_sequencer.sv
// Sequences a PLL reconfiguration from debounced board switches and holds video until lock settles.
// Optional lock timeouts and the FAULT state are enabled by defining PLL_SEQ_TIMEOUT_EN.
module pll_mode_sequencer
   import vpg_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES     = DEBOUNCE_CYCLES_DEF,
   parameter int CHANGE_PULSE_CYCLES = CHANGE_PULSE_CYCLES_DEF,
   parameter int LOCK_TIMEOUT_CYCLES = LOCK_TIMEOUT_CYCLES_DEF,
   parameter int SETTLE_CYCLES       = SETTLE_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] mode_sw,
   input  logic       pll_locked,
   output logic [3:0] mode,
   output logic       mode_change,
   output logic       video_reset_n,
   output logic       busy,
   output logic       error
);

   localparam int CNT_W = cnt_width(CHANGE_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, SETTLE_CYCLES);
   localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(CHANGE_PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);

   logic [3:0]       cand;
   logic             stable;
   logic [1:0]       lock_sync_q;
   logic             lock_s;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       mode_q, mode_d;
   logic             mode_change_q, mode_change_d;
   logic             video_rst_n_q, video_rst_n_d;
   logic             first_req_q, first_req_d;
   logic             error_q, error_d;
   logic             req_ok;

   mode_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (mode_sw),
      .dout    (cand),
      .stable  (stable)
   );

   assign lock_s = lock_sync_q[1];
   assign req_ok = stable && ((cand != mode_q) || first_req_q);

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d       = state_q;
      cnt_d         = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
      mode_d        = mode_q;
      mode_change_d = 1'b0;
      video_rst_n_d = video_rst_n_q;
      first_req_d   = first_req_q;
      error_d       = error_q;
      unique case (state_q)
         ST_IDLE
`ifdef PLL_SEQ_TIMEOUT_EN
         , ST_FAULT
`endif
         : begin
            cnt_d = cnt_q;
            if (req_ok) begin
               mode_d        = cand;
               first_req_d   = 1'b0;
               error_d       = 1'b0;
               video_rst_n_d = 1'b0;
               mode_change_d = 1'b1;
               cnt_d         = PULSE_LD;
               state_d       = ST_REQUEST;
            end
         end
         ST_REQUEST: begin
            mode_change_d = 1'b1;
            if (cnt_q == '0) begin
               mode_change_d = 1'b0;
               cnt_d         = TIMEOUT_LD;
               state_d       = ST_WAIT_UNLOCK;
            end
         end
         ST_WAIT_UNLOCK: begin
            if (!lock_s) begin
               cnt_d   = TIMEOUT_LD;
               state_d = ST_WAIT_LOCK;
            end
`ifdef PLL_SEQ_TIMEOUT_EN
            // A PLL that never reports unlock is not an error; just move on to wait for lock.
            else if (cnt_q == '0) begin
               cnt_d   = TIMEOUT_LD;
               state_d = ST_WAIT_LOCK;
            end
`endif
         end
         ST_WAIT_LOCK: begin
            if (lock_s) begin
               cnt_d   = SETTLE_LD;
               state_d = ST_SETTLE;
            end
`ifdef PLL_SEQ_TIMEOUT_EN
            else if (cnt_q == '0) begin
               error_d = 1'b1;
               state_d = ST_FAULT;
            end
`endif
         end
         ST_SETTLE: begin
            if (!lock_s) begin
               cnt_d   = TIMEOUT_LD;
               state_d = ST_WAIT_LOCK;
            end else if (cnt_q == '0) begin
               video_rst_n_d = 1'b1;
               state_d       = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         lock_sync_q   <= '0;
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         mode_q        <= '0;
         mode_change_q <= 1'b0;
         video_rst_n_q <= 1'b0;
         first_req_q   <= 1'b1;
         error_q       <= 1'b0;
      end else begin
         lock_sync_q   <= {lock_sync_q[0], pll_locked};
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         mode_q        <= mode_d;
         mode_change_q <= mode_change_d;
         video_rst_n_q <= video_rst_n_d;
         first_req_q   <= first_req_d;
         error_q       <= error_d;
      end
   end

   assign mode          = mode_q;
   assign mode_change   = mode_change_q;
   assign video_reset_n = video_rst_n_q;
   assign busy          = (state_q != ST_IDLE);
`ifdef PLL_SEQ_TIMEOUT_EN
   assign error         = error_q;
`else
   assign error         = 1'b0;
`endif

endmodule

// File: tb/tb_pll_mode_sequencer.sv
// Scoreboard bench: expected modes are queued when switches move and popped on each mode_change rise.
module tb_pll_mode_sequencer;

   localparam int DEB    = 8;
   localparam int PULSE  = 4;
   localparam int TMO    = 64;
   localparam int SETTLE = 16;
   // Raw lock rise -> 2 synchronizer edges -> FSM edge into SETTLE -> SETTLE locked cycles.
   localparam int RISE_TO_VIDEO = 3 + SETTLE;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [3:0] exp_q[$];
   int   rises = 0;
   int   mc_len = 0;
   bit   mc_prev = 1'b0;
   bit   aborted = 1'b0;

   pll_mode_sequencer_if tb_if ();

   pll_mode_sequencer #(
      .DEBOUNCE_CYCLES     (DEB),
      .CHANGE_PULSE_CYCLES (PULSE),
      .LOCK_TIMEOUT_CYCLES (TMO),
      .SETTLE_CYCLES       (SETTLE)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .mode_sw       (tb_if.mode_sw),
      .pll_locked    (tb_if.pll_locked),
      .mode          (tb_if.mode),
      .mode_change   (tb_if.mode_change),
      .video_reset_n (tb_if.video_reset_n),
      .busy          (tb_if.busy),
      .error         (tb_if.error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Request monitor: pops the scoreboard on each rise and checks pulse length on each fall.
   always @(negedge clk) begin
      if (!reset_n) aborted = 1'b1;
      if (tb_if.mode_change && !mc_prev) begin
         rises++;
         mc_len  = 1;
         aborted = 1'b0;
         check("sb_nonempty", 32'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) check("req_mode", tb_if.mode, exp_q.pop_front());
      end else if (tb_if.mode_change) begin
         mc_len++;
      end else if (mc_prev && !aborted) begin
         check("pulse_len", mc_len, PULSE);
      end
      mc_prev = tb_if.mode_change;
   end

   task automatic wait_mc(input logic lvl);
      int n = 0;
      while (tb_if.mode_change !== lvl && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) check("mc_wait", tb_if.mode_change, lvl);
   endtask

   task automatic raise_and_settle(input string tag);
      int n = 0;
      tb_if.pll_locked = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (tb_if.video_reset_n !== 1'b1 && n < 200);
      check(tag, n, RISE_TO_VIDEO);
   endtask

   task automatic run_lock(input bit glitch);
      wait_mc(1'b1);
      wait_mc(1'b0);
      check("vrst_low_req", tb_if.video_reset_n, 0);
      tb_if.pll_locked = 1'b0;
      repeat (4) @(negedge clk);
      if (glitch) begin
         tb_if.pll_locked = 1'b1;
         repeat (10) @(negedge clk);
         tb_if.pll_locked = 1'b0;
         repeat (3) @(negedge clk);
         check("vrst_glitch", tb_if.video_reset_n, 0);
      end
      raise_and_settle("settle_len");
   endtask

   initial begin
      int rc;
      int n;
      tb_if.mode_sw    = 4'h0;
      tb_if.pll_locked = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_mode", tb_if.mode, 0);
      check("rst_mc", tb_if.mode_change, 0);
      check("rst_vrst", tb_if.video_reset_n, 0);
      check("rst_err", tb_if.error, 0);
      check("rst_busy", tb_if.busy, 0);

      // Power-up: equal switch value still requests once.
      exp_q.push_back(4'h0);
      reset_n = 1'b1;
      run_lock(1'b0);
      check("pu_busy", tb_if.busy, 0);

      // Bounce: no request while the switches chatter.
      rc = rises;
      exp_q.push_back(4'h3);
      for (int i = 0; i < 8; i++) begin
         tb_if.mode_sw = (i % 2 == 0) ? 4'h3 : 4'h0;
         repeat (5) @(negedge clk);
      end
      check("bounce_quiet", rises, rc);
      tb_if.mode_sw = 4'h3;
      run_lock(1'b0);
      check("bounce_once", rises, rc + 1);
      check("bounce_mode", tb_if.mode, 4'h3);

      // Lock never returns after a request.
      exp_q.push_back(4'hC);
      tb_if.mode_sw = 4'hC;
      wait_mc(1'b1);
      wait_mc(1'b0);
      tb_if.pll_locked = 1'b0;
`ifdef PLL_SEQ_TIMEOUT_EN
      n = 0;
      while (tb_if.error !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("tmo_error", tb_if.error, 1);
      check("tmo_busy", tb_if.busy, 1);
      check("tmo_vrst", tb_if.video_reset_n, 0);
      exp_q.push_back(4'h5);
      tb_if.mode_sw = 4'h5;
      wait_mc(1'b1);
      check("tmo_err_clr", tb_if.error, 0);
      run_lock(1'b0);
`else
      n = 150;
      repeat (n) @(negedge clk);
      check("wait_noerr", tb_if.error, 0);
      check("wait_busy", tb_if.busy, 1);
      exp_q.push_back(4'h5);
      tb_if.mode_sw = 4'h5;
      repeat (20) @(negedge clk);
      raise_and_settle("late_lock");
      run_lock(1'b0);
`endif
      check("tmo_mode", tb_if.mode, 4'h5);

      // Lock glitch during SETTLE restarts the full settle time.
      exp_q.push_back(4'h9);
      tb_if.mode_sw = 4'h9;
      run_lock(1'b1);
      check("glitch_mode", tb_if.mode, 4'h9);

      // Switch change while busy is deferred until IDLE.
      exp_q.push_back(4'hA);
      tb_if.mode_sw = 4'hA;
      wait_mc(1'b1);
      wait_mc(1'b0);
      tb_if.pll_locked = 1'b0;
      repeat (5) @(negedge clk);
      rc = rises;
      exp_q.push_back(4'h7);
      tb_if.mode_sw = 4'h7;
      repeat (20) @(negedge clk);
      check("busy_hold_mode", tb_if.mode, 4'hA);
      raise_and_settle("busy_settle");
      check("busy_no_req", rises, rc);
      run_lock(1'b0);
      check("busy_mode", tb_if.mode, 4'h7);

      // Reset in the second pulse cycle aborts the request.
      exp_q.push_back(4'h2);
      tb_if.mode_sw = 4'h2;
      wait_mc(1'b1);
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      check("rstmid_mc", tb_if.mode_change, 0);
      check("rstmid_mode", tb_if.mode, 0);
      check("rstmid_busy", tb_if.busy, 0);
      repeat (2) @(negedge clk);
      exp_q.push_back(4'h2);
      reset_n = 1'b1;
      run_lock(1'b0);
      check("final_mode", tb_if.mode, 4'h2);
      check("final_busy", tb_if.busy, 0);
      check("final_err", tb_if.error, 0);
      repeat (20) @(negedge clk);
      check("sb_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pll_mode_sequencer.md
PLL_MODE_SEQUENCER -- requirements
Module: pll_mode_sequencer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000: cycles `mode_sw` must stay stable before acceptance.
REQ-002 SHALL have parameter CHANGE_PULSE_CYCLES, default 4: `mode_change` high time, which must cover the pll_controller 3-flop edge detector.
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 1000000: maximum wait in WAIT_UNLOCK or WAIT_LOCK.
REQ-004 SHALL have parameter SETTLE_CYCLES, default 1024: continuous lock time before video release.
REQ-005 SHALL have port `clk`, input, 1 bit: single clock, which also runs pll_controller.
REQ-006 SHALL have port `reset_n`, input, 1 bit: reset, synchronous, active-low.
REQ-007 SHALL have port `mode_sw`, input, 4 bits: raw board switches, asynchronous.
REQ-008 SHALL have port `pll_locked`, input, 1 bit: reconfigured PLL lock, asynchronous.
REQ-009 SHALL have port `mode`, output, 4 bits: registered mode selection to pll_controller.
REQ-010 SHALL have port `mode_change`, output, 1 bit: reconfiguration request level to pll_controller.
REQ-011 SHALL have port `video_reset_n`, output, 1 bit: active-low hold of the downstream timing generator.
REQ-012 SHALL have port `busy`, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port `error`, output, 1 bit: lock timeout flag.

Function
REQ-014 SHALL pass `mode_sw` and `pll_locked` through 2-flop synchronizers before any use.
REQ-015 SHALL debounce as follows: a candidate register loads on any synchronized change and the stability counter clears; `stable` asserts when the counter reaches DEBOUNCE_CYCLES-1, and the counter saturates there.
REQ-016 SHALL implement states IDLE, REQUEST, WAIT_UNLOCK, WAIT_LOCK, SETTLE, FAULT.
REQ-017 SHALL, in IDLE or FAULT, when `stable` and (candidate != `mode` or first_req), load `mode` with the candidate, clear first_req and `error`, drive `video_reset_n`=0, and enter REQUEST on the next cycle.
REQ-018 SHALL drive `mode_change`=1 for exactly CHANGE_PULSE_CYCLES cycles in REQUEST, then 0, then enter WAIT_UNLOCK.
REQ-019 SHALL, in WAIT_UNLOCK, enter WAIT_LOCK on synced lock=0; if lock never drops, SHALL enter WAIT_LOCK after LOCK_TIMEOUT_CYCLES without flagging an error.
REQ-020 SHALL, in WAIT_LOCK, enter SETTLE on synced lock=1 and enter FAULT on timeout.
REQ-021 SHALL, in SETTLE, return to WAIT_LOCK on lock loss (timeout counter restarted), and after SETTLE_CYCLES consecutive locked cycles enter IDLE with `video_reset_n`=1.
REQ-022 SHALL, in FAULT, hold `error`=1 and `video_reset_n`=0 until a REQ-017 request occurs.
REQ-023 SHALL, for switch changes while outside IDLE/FAULT, keep debouncing but not act on them; a change still differing from `mode` on return to IDLE SHALL trigger a new request.
REQ-024 SHALL use one shared down-counter, 20 bits minimum, for the pulse, timeout and settle phases, reloaded on every state entry.
REQ-025 SHALL leave `mode` unchanged in every state except the REQ-017 transition.

Reset
REQ-026 SHALL, when `reset_n`=0 at a clock edge, set state=IDLE, `mode`=0, `mode_change`=0, `video_reset_n`=0, `error`=0, `busy`=0, first_req=1, and clear counters and synchronizers.
REQ-027 SHALL, on reset asserted mid-sequence, abort the sequence in the same edge; `mode_change` SHALL never be left high.

Configuration
REQ-028 SHALL, with PLL_SEQ_TIMEOUT_EN defined, implement the timeouts and the FAULT state per REQ-019 to REQ-022.
REQ-029 SHALL, without PLL_SEQ_TIMEOUT_EN, have WAIT_UNLOCK and WAIT_LOCK wait indefinitely, remove FAULT, and tie `error` to 0.

Structure
REQ-030 SHALL place the state encoding enum and the default parameter constants in shared package vpg_pkg.
REQ-031 SHALL implement the synchronizer and debouncer of REQ-014/015 as sub-module mode_debounce (4-bit data, `stable` output).

Verification (DEBOUNCE_CYCLES=8, CHANGE_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=64, SETTLE_CYCLES=16)
REQ-032 SHALL cover power-up: reset released with `mode_sw`=4'h0 and lock toggled low then high -> request issued despite equal value, `mode_change` high exactly 4 cycles, `video_reset_n` rises 16 cycles after lock.
REQ-033 SHALL cover bounce: `mode_sw` toggles 4'h3/4'h0 every 5 cycles for 40 cycles, then holds 4'h3 -> exactly one request, `mode`=4'h3, no `mode_change` during bouncing.
REQ-034 SHALL cover the timeout: `pll_locked` held 0 after the request -> `error`=1 and state FAULT; a new switch value 4'h5 then gives `error`=0 and a new request.
REQ-035 SHALL cover lock glitch: lock drops at settle cycle 10 -> re-enter WAIT_LOCK, full 16 cycles again before `video_reset_n`=1.
REQ-036 SHALL cover busy-time change: switch moves to 4'h7 during WAIT_LOCK -> ignored until IDLE, then a second request with `mode`=4'h7.
REQ-037 SHALL cover reset mid-REQUEST: `reset_n`=0 at pulse cycle 2 -> `mode_change`=0 and `mode`=0 at the next edge.
